// File: rtl/traffic_phase_ctrl.sv
// Four-phase traffic controller: sequences phases for a downstream countdown stage,
// drives NS/EW lamps, counts completed rounds, and supports an all-red emergency hold.
module traffic_phase_ctrl (
    input  logic       C_CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       EMG,
    input  logic       C_out,
    output logic       C_EN,
    output logic       line_0,
    output logic       line_1,
    output logic       line_2,
    output logic       line_3,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic [7:0] round_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    localparam logic [1:0] OFF = 2'b00, GRN = 2'b01, YEL = 2'b10, RED = 2'b11;

    state_t     state, state_next;
    logic [1:0] phase, phase_next;
    logic [7:0] rc_next;
    logic       armed;
    logic       c_en_q;

    // armed is low during the first RUN cycle so a stale done pulse is masked
    always_ff @(posedge C_CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            phase     <= 2'd0;
            round_cnt <= 8'd0;
            armed     <= 1'b0;
            c_en_q    <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            round_cnt <= rc_next;
            armed     <= (state == RUN);
            c_en_q    <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        rc_next    = round_cnt;
        if (EMG) begin
            state_next = HOLD;
        end else begin
            case (state)
                IDLE: begin
                    phase_next = 2'd0;
                    if (START) state_next = LOAD;
                end
                LOAD: begin
                    if (!START) begin
                        state_next = IDLE;
                        phase_next = 2'd0;
                    end else begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!START) begin
                        state_next = IDLE;
                        phase_next = 2'd0;
                    end else if (armed && C_out) begin
                        state_next = LOAD;
                        phase_next = phase + 2'd1;
                        if (phase == 2'd3) rc_next = round_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    phase_next = 2'd0;
                    state_next = START ? LOAD : IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        C_EN     = c_en_q;
        line_0   = 1'b0;
        line_1   = 1'b0;
        line_2   = 1'b0;
        line_3   = 1'b0;
        ns_light = OFF;
        ew_light = OFF;
        case (state)
            LOAD, RUN: begin
                line_0 = (phase == 2'd0);
                line_1 = (phase == 2'd1);
                line_2 = (phase == 2'd2);
                line_3 = (phase == 2'd3);
                case (phase)
                    2'd0:    begin ns_light = GRN; ew_light = RED; end
                    2'd1:    begin ns_light = YEL; ew_light = RED; end
                    2'd2:    begin ns_light = RED; ew_light = GRN; end
                    default: begin ns_light = RED; ew_light = YEL; end
                endcase
            end
            HOLD: begin
                ns_light = RED;
                ew_light = RED;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl; expected outputs are queued when a step is
// driven and popped/compared one time unit after the following rising edge.
module tb_traffic_phase_ctrl;
    logic       C_CLK = 1'b0;
    logic       RST   = 1'b0;
    logic       START = 1'b0;
    logic       EMG   = 1'b0;
    logic       C_out = 1'b0;
    logic       C_EN;
    logic       line_0, line_1, line_2, line_3;
    logic [1:0] ns_light, ew_light;
    logic [7:0] round_cnt;

    int total = 0;
    int bad   = 0;
    int exp_rc = 0;

    logic [16:0] exp_q[$];
    string       tag_q[$];

    traffic_phase_ctrl dut (
        .C_CLK(C_CLK), .RST(RST), .START(START), .EMG(EMG), .C_out(C_out),
        .C_EN(C_EN), .line_0(line_0), .line_1(line_1), .line_2(line_2), .line_3(line_3),
        .ns_light(ns_light), .ew_light(ew_light), .round_cnt(round_cnt)
    );

    always #5 C_CLK = ~C_CLK;

    // {C_EN, line_3..line_0, ns, ew, round_cnt}
    function automatic logic [16:0] ev_phase(input logic en, input int ph, input int rc);
        logic [3:0] ln;
        logic [3:0] lamps;
        case (ph)
            0: begin ln = 4'b0001; lamps = 4'b01_11; end
            1: begin ln = 4'b0010; lamps = 4'b10_11; end
            2: begin ln = 4'b0100; lamps = 4'b11_01; end
            default: begin ln = 4'b1000; lamps = 4'b11_10; end
        endcase
        return {en, ln, lamps, 8'(rc)};
    endfunction

    function automatic logic [16:0] ev_hold(input int rc);
        return {1'b0, 4'b0000, 4'b11_11, 8'(rc)};
    endfunction

    function automatic logic [16:0] ev_idle(input int rc);
        return {1'b0, 4'b0000, 4'b00_00, 8'(rc)};
    endfunction

    task automatic compare(input logic [16:0] exp_v, input string tag);
        logic [16:0] got;
        got = {C_EN, line_3, line_2, line_1, line_0, ns_light, ew_light, round_cnt};
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp_v);
        end
    endtask

    task automatic step(input logic s, input logic e, input logic c,
                        input logic [16:0] exp_v, input string tag);
        @(negedge C_CLK);
        START = s; EMG = e; C_out = c;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(posedge C_CLK);
        #1;
        compare(exp_q.pop_front(), tag_q.pop_front());
    endtask

    // Starting in LOAD of phase ph: two RUN cycles, then a done pulse advances.
    task automatic run_phase(input int ph);
        int nxt;
        nxt = (ph + 1) % 4;
        step(1, 0, 0, ev_phase(1'b1, ph, exp_rc), "run_c1");
        step(1, 0, 0, ev_phase(1'b1, ph, exp_rc), "run_c2");
        if (ph == 3) exp_rc = (exp_rc + 1) % 256;
        step(1, 0, 1, ev_phase(1'b0, nxt, exp_rc), "advance");
    endtask

    initial begin
        #2;
        compare(ev_idle(0), "reset_state");
        @(negedge C_CLK);
        RST = 1'b1;
        step(0, 0, 0, ev_idle(0), "idle_hold");
        step(1, 0, 0, ev_phase(1'b0, 0, 0), "idle_to_load");
        step(1, 0, 0, ev_phase(1'b1, 0, 0), "load_to_run");
        step(1, 0, 1, ev_phase(1'b1, 0, 0), "stale_cout_masked");
        step(1, 0, 0, ev_phase(1'b1, 0, 0), "run_third_wait");
        step(1, 0, 1, ev_phase(1'b0, 1, 0), "adv_to_p1");
        run_phase(1);
        run_phase(2);
        run_phase(3);
        compare(ev_phase(1'b0, 0, 1), "round_one");

        // emergency during phase 2, C_out also asserted
        run_phase(0);
        run_phase(1);
        step(1, 0, 0, ev_phase(1'b1, 2, 1), "p2_run");
        step(1, 1, 1, ev_hold(1), "emg_to_hold");
        step(1, 1, 0, ev_hold(1), "hold_persist");
        step(1, 0, 0, ev_phase(1'b0, 0, 1), "hold_to_load_p0");
        run_phase(0);
        step(1, 0, 0, ev_phase(1'b1, 1, 1), "p1_c1");
        step(1, 0, 0, ev_phase(1'b1, 1, 1), "p1_c2");
        step(0, 0, 1, ev_idle(1), "stop_beats_cout");
        step(0, 1, 0, ev_hold(1), "idle_emg");
        step(0, 0, 0, ev_idle(1), "hold_to_idle");
        step(1, 0, 0, ev_phase(1'b0, 0, 1), "restart_p0");

        // 255 more rounds wraps round_cnt back to 0
        for (int r = 0; r < 255; r++)
            for (int ph = 0; ph < 4; ph++)
                run_phase(ph);
        compare(ev_phase(1'b0, 0, 0), "round_wrap");

        // asynchronous reset mid-RUN
        step(1, 0, 0, ev_phase(1'b1, 0, 0), "pre_reset_run");
        #2;
        RST = 1'b0; START = 1'b0;
        #1;
        compare(ev_idle(0), "async_reset");
        @(negedge C_CLK);
        RST = 1'b1;
        #1;
        compare(ev_idle(0), "reset_release");
        step(0, 0, 0, ev_idle(0), "post_reset_idle");
        step(1, 0, 0, ev_phase(1'b0, 0, 0), "post_reset_load");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
